// File: rtl/cla_seq_adder_pkg.sv
// Shared definitions for the sequential lookahead adder: FSM state encoding
// and the index-counter width helper.
package cla_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cla_seq_adder_if.sv
// Handshake/operand bundle between a controlling datapath (master) and the
// sequential adder (slave). The ovf signal exists only with CLA_OVF_EN.
interface cla_seq_adder_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/cla_seq_adder_lcu.sv
// Flat lookahead carry unit for one CHUNK-wide slice: every carry is a
// two-level sum of products of g/p and the slice carry-in.
module cla_lcu #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_g,
  input  logic [CHUNK-1:0] i_p,
  input  logic             i_c0,
  output logic [CHUNK:1]   o_c,
  output logic             o_grp_g,
  output logic             o_grp_p
);

  // c_{top+1} = g_top | p_top&g_{top-1} | ... | p_top..p_0 & c0
  function automatic logic la_carry(input logic [CHUNK-1:0] g,
                                    input logic [CHUNK-1:0] p,
                                    input logic             c0,
                                    input int               top);
    logic prop;
    logic res;
    prop = 1'b1;
    res  = 1'b0;
    for (int j = CHUNK - 1; j >= 0; j--) begin
      if (j <= top) begin
        res  = res | (prop & g[j]);
        prop = prop & p[j];
      end
    end
    return res | (prop & c0);
  endfunction

  always_comb begin
    o_c = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_c[i+1] = la_carry(i_g, i_p, i_c0, i);
    end
  end

  assign o_grp_g = la_carry(i_g, i_p, 1'b0, CHUNK - 1);
  assign o_grp_p = &i_p;

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one CHUNK-bit slice per clock through a pfa row and a
// flat LCU, carry registered between slices. Optional ovf via CLA_OVF_EN.
module cla_seq_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst,
  cla_seq_adder_if.slave  bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IDXW-1:0]  r_idx;

  int               w_base;
  logic [CHUNK-1:0] w_a_sl;
  logic [CHUNK-1:0] w_b_sl;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_s;
  logic [CHUNK:1]   w_c;
  logic [CHUNK:0]   w_cc;
  logic             w_grp_g;
  logic             w_grp_p;
  logic             w_carry_out;
  logic             w_last;

  assign w_base = int'(r_idx) * CHUNK;
  assign w_a_sl = r_a[w_base +: CHUNK];
  assign w_b_sl = r_b[w_base +: CHUNK];

  assign w_p = w_a_sl ^ w_b_sl;
  assign w_g = w_a_sl & w_b_sl;

  cla_lcu #(.CHUNK(CHUNK)) u_lcu (
    .i_g     (w_g),
    .i_p     (w_p),
    .i_c0    (r_carry),
    .o_c     (w_c),
    .o_grp_g (w_grp_g),
    .o_grp_p (w_grp_p)
  );

  assign w_cc        = {w_c, r_carry};
  assign w_s         = w_p ^ w_cc[CHUNK-1:0];
  assign w_carry_out = w_grp_g | (w_grp_p & r_carry);
  assign w_last      = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy = (r_state == ST_RUN);
  assign bus.done = (r_state == ST_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_sum   <= '0;
            r_idx   <= '0;
          end
        end
        ST_RUN: begin
          r_sum[w_base +: CHUNK] <= w_s;
          r_carry                <= w_carry_out;
          r_idx                  <= w_last ? '0 : r_idx + 1'b1;
          if (w_last) r_cout <= w_carry_out;
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_ovf <= 1'b0;
    else if (r_state == ST_RUN && w_last) r_ovf <= w_cc[CHUNK-1] ^ w_cc[CHUNK];
  end

  assign bus.ovf = r_ovf;
`else
  logic w_unused_msb_c;
  assign w_unused_msb_c = w_cc[CHUNK];
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized and directed checks of cla_seq_adder against an arithmetic
// reference; ovf is checked when built with CLA_OVF_EN.
module tb_cla_seq_adder;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cla_seq_adder_if #(.WIDTH(WIDTH)) intf ();

  cla_seq_adder #(.WIDTH(WIDTH), .CHUNK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (intf)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Plain integer arithmetic; signed overflow = carry into bit 15 ^ carry out of bit 15.
  task automatic ref_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output logic [15:0] s, output logic co, output logic ov);
    int full;
    int low;
    full = int'(a) + int'(b) + int'(c);
    low  = int'(a & 16'h7fff) + int'(b & 16'h7fff) + int'(c);
    s    = 16'(full);
    co   = (full >= 65536);
    ov   = (low >= 32768) ^ co;
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input bit restart);
    logic [15:0] s;
    logic co;
    logic ov;
    int n;
    ref_add(a, b, c, s, co, ov);
    @(negedge clk);
    intf.start = 1'b1;
    intf.a     = a;
    intf.b     = b;
    intf.cin   = c;
    @(negedge clk);
    if (restart) begin
      intf.a = 16'hAAAA;
    end else begin
      intf.start = 1'b0;
      intf.a     = 16'($urandom);
      intf.b     = 16'($urandom);
      intf.cin   = 1'($urandom);
    end
    n = 0;
    while (intf.busy === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
    end
    intf.start = 1'b0;
    chk("busy_cycles", 32'(n), 32'd4);
    chk("done", 32'(intf.done), 32'd1);
    chk("sum", 32'(intf.sum), 32'(s));
    chk("cout", 32'(intf.cout), 32'(co));
`ifdef CLA_OVF_EN
    chk("ovf", 32'(intf.ovf), 32'(ov));
`endif
    @(negedge clk);
    chk("done_pulse", 32'(intf.done), 32'd0);
    chk("sum_hold", 32'(intf.sum), 32'(s));
    @(negedge clk);
    chk("idle_busy", 32'(intf.busy), 32'd0);
    chk("idle_done", 32'(intf.done), 32'd0);
  endtask

  logic [15:0] dir_a [6] = '{16'h1234, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000};
  logic [15:0] dir_b [6] = '{16'h4321, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'hFFFF};
  logic        dir_c [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    intf.start = 1'b0;
    intf.a     = '0;
    intf.b     = '0;
    intf.cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(intf.busy), 32'd0);
    chk("rst_done", 32'(intf.done), 32'd0);
    chk("rst_sum", 32'(intf.sum), 32'd0);
    chk("rst_cout", 32'(intf.cout), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i], dir_c[i], 1'b0);

    // Start re-asserted with new operands throughout RUN must be ignored.
    run_op(16'h0F0F, 16'h0101, 1'b0, 1'b1);

    // Reset after two RUN edges discards the operation immediately.
    @(negedge clk);
    intf.start = 1'b1;
    intf.a     = 16'h1234;
    intf.b     = 16'h4321;
    intf.cin   = 1'b0;
    @(negedge clk);
    intf.start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(intf.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_sum", 32'(intf.sum), 32'd0);
    chk("arst_cout", 32'(intf.cout), 32'd0);
    chk("arst_busy", 32'(intf.busy), 32'd0);
    chk("arst_done", 32'(intf.done), 32'd0);
`ifdef CLA_OVF_EN
    chk("arst_ovf", 32'(intf.ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0);

    repeat (40) run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
